// File: rtl/io_bridge_pkg.sv
// Shared constants for the io_bridge: the default address map, the timer
// register offsets, the CTRL bit layout, MODE codes and the timer FSM encoding.
package io_bridge_pkg;

  // Default address map: data memory below DM_LIMIT, 3-word timer block at TMR_BASE
  localparam logic [31:0] DM_LIMIT_DEF = 32'h0000_3000;
  localparam logic [31:0] TMR_BASE_DEF = 32'h0000_7F00;

  // Word index of each timer register (addr[3:2]); index 3 is unmapped
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_NONE   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // MODE codes; 10 and 11 fall back to one-shot behaviour
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Timer FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // Implemented CTRL bits, laid out to match the bit positions above
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // Zero-extends the 4 implemented CTRL bits to a full read word
  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    return {28'd0, c};
  endfunction

endpackage

// File: rtl/io_bridge_timer_unit.sv
// Countdown timer: CTRL/PRESET/COUNT registers, the IDLE/LOAD/CNT/INT
// sequencer, the interrupt flag and the registered interrupt output.
module timer_unit
  import io_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_we,
  input  logic        preset_we,
  input  logic [31:0] wdata,
  output ctrl_t       ctrl,
  output logic [31:0] preset,
  output logic [31:0] count,
  output logic        irq
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] count_nxt;
  logic        irq_flag;
  logic        flag_nxt;
  logic        en_eff;
  logic        en_nxt;
  ctrl_t       ctrl_in;

  // A CPU write to CTRL takes effect on the same edge, so the sequencer
  // looks at the value EN is about to hold rather than the stored one.
  assign ctrl_in = ctrl_t'(wdata[3:0]);
  assign en_eff  = ctrl_we ? ctrl_in.en : ctrl.en;

  // Next-state, count and flag logic; a CPU CTRL write beats the hardware EN clear
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_nxt  = ctrl_we ? 1'b0 : irq_flag;
    en_nxt    = en_eff;
    case (state)
      ST_IDLE: begin
        if (en_eff) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!en_eff) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          count_nxt = 32'd0;
          flag_nxt  = 1'b1;
          state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl.mode == MODE_RELOAD) begin
          flag_nxt  = 1'b0;
          state_nxt = en_eff ? ST_LOAD : ST_IDLE;
        end else begin
          if (!ctrl_we) en_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Register update; irq is the previous cycle's masked flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      irq_flag <= flag_nxt;
      ctrl.en  <= en_nxt;
      if (ctrl_we) begin
        ctrl.mode <= ctrl_in.mode;
        ctrl.im   <= ctrl_in.im;
      end
      if (preset_we) preset <= wdata;
      irq <= irq_flag & ctrl.im;
    end
  end

endmodule

// File: rtl/io_bridge.sv
// Memory-side bridge for the single-cycle core: decodes the data address into
// the external data memory or the timer block and returns read data in the
// same cycle.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter logic [31:0] DM_LIMIT = DM_LIMIT_DEF,
  parameter logic [31:0] TMR_BASE = TMR_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  input  logic [31:0] dm_rdata,
  output logic        irq
);

  logic        dm_hit;
  logic        tmr_hit;
  ctrl_t       ctrl;
  logic [31:0] preset;
  logic [31:0] count;

  // Address decode; the low two address bits are ignored inside the timer block
  assign dm_hit  = addr < DM_LIMIT;
  assign tmr_hit = (addr[31:4] == TMR_BASE[31:4]) && (addr[3:2] != REG_NONE);

  assign dm_addr  = addr;
  assign dm_wdata = wdata;
  assign dm_we    = we & dm_hit;

  timer_unit u_timer (
    .clk       (clk),
    .reset     (reset),
    .ctrl_we   (we & tmr_hit & (addr[3:2] == REG_CTRL)),
    .preset_we (we & tmr_hit & (addr[3:2] == REG_PRESET)),
    .wdata     (wdata),
    .ctrl      (ctrl),
    .preset    (preset),
    .count     (count),
    .irq       (irq)
  );

  // Zero-latency read mux; unmapped addresses read as zero
  always_comb begin
    rdata = 32'd0;
    if (dm_hit) begin
      rdata = dm_rdata;
    end else if (tmr_hit) begin
      case (addr[3:2])
        REG_CTRL:   rdata = ctrl_word(ctrl);
        REG_PRESET: rdata = preset;
        REG_COUNT:  rdata = count;
        default:    rdata = 32'd0;
      endcase
    end
  end

endmodule
